// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, command codes and frame widths shared by the SPI master and slave.
package spi_pkg;
    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    typedef enum logic [2:0] {IDLE, SELECT, SHIFT_OUT, WAIT_RD, SHIFT_IN, DESELECT} state_t;
    typedef enum logic [1:0] {WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11} cmd_t;
endpackage

// File: rtl/spi_master.sv
// spi_master: sends a 10-bit command frame MSB first and, for rd-data frames, shifts a byte back in after RD_WAIT idle cycles.
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        cmd_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);
    localparam logic [3:0] WAIT_LAST = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);
    state_t              r_state, w_next;
    cmd_t                r_cmd;
    logic [3:0]          r_cnt;
    logic [FRAME_W-1:0]  r_tx;
    logic [DATA_W-1:0]   r_rx, r_rd_data;
    logic                r_ss_n, r_mosi;
    always_comb begin
        w_next   = r_state;
        busy     = r_state != IDLE;
        done     = r_state == DESELECT;
        rd_valid = r_state == DESELECT && r_cmd == RD_DATA;
        unique case (r_state)
            IDLE:      w_next = start ? SELECT : IDLE;
            SELECT:    w_next = SHIFT_OUT;
            SHIFT_OUT: if (r_cnt == 4'd9) w_next = (r_cmd != RD_DATA) ? DESELECT : (RD_WAIT == 0) ? SHIFT_IN : WAIT_RD;
            WAIT_RD:   if (r_cnt == WAIT_LAST) w_next = SHIFT_IN;
            SHIFT_IN:  if (r_cnt == 4'd7) w_next = DESELECT;
            DESELECT:  w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end
    // ss_n/mosi are registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cmd     <= WR_ADDR;
            r_cnt     <= 4'd0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rd_data <= '0;
            r_ss_n    <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 4'd0 : (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
            r_ss_n  <= w_next == IDLE || w_next == DESELECT;
            r_mosi  <= (w_next == SHIFT_OUT) ? ((r_state == SHIFT_OUT) ? r_tx[FRAME_W-2] : r_tx[FRAME_W-1]) : 1'b0;
            if (r_state == IDLE && start) begin
                r_tx  <= cmd_data;
                r_cmd <= cmd_t'(cmd_data[9:8]);
            end else if (r_state == SHIFT_OUT) begin
                r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
            end
            if (r_state == SHIFT_IN)
                r_rx <= {r_rx[DATA_W-2:0], miso};
            if (r_state == SHIFT_IN && w_next == DESELECT)
                r_rd_data <= {r_rx[DATA_W-2:0], miso};
        end
    end
    assign ss_n    = r_ss_n;
    assign mosi    = r_mosi;
    assign rd_data = r_rd_data;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of frame timing, read capture, busy/back-to-back behaviour, reset abort and a RAM-slave loopback.
module tb_spi_master;
    localparam int RD_WAIT = 3;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] cmd_data = '0;
    logic       miso = 1'b0;
    logic       busy, done, rd_valid, ss_n, mosi;
    logic [7:0] rd_data;
    int tests_run = 0;
    int tests_failed = 0;
    logic [47:0] tr_ss, tr_mosi, tr_done, tr_valid, tr_busy;
    int          done_cyc;
    logic [7:0]  rd_at_done;
    logic [9:0]  sl_frame;

    spi_master #(.RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_data(cmd_data), .busy(busy), .done(done),
        .rd_data(rd_data), .rd_valid(rd_valid), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Called at #1 after a clock edge while IDLE; that cycle is cycle 0, start is sampled at its end.
    task automatic run_frame(input logic [9:0] cmd, input logic [7:0] rx, input int pulse_at);
        start = 1'b1; cmd_data = cmd; miso = 1'b0;
        tr_ss = '1; tr_mosi = '0; tr_done = '0; tr_valid = '0; tr_busy = '0;
        done_cyc = 0; rd_at_done = '0;
        for (int c = 1; c < 48; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c == pulse_at) begin start = 1'b1; cmd_data = ~cmd; end
            if (c == pulse_at + 1) start = 1'b0;
            tr_ss[c] = ss_n; tr_mosi[c] = mosi; tr_done[c] = done; tr_valid[c] = rd_valid; tr_busy[c] = busy;
            if (done && done_cyc == 0) begin done_cyc = c; rd_at_done = rd_data; end
            miso = (c >= 12 + RD_WAIT && c < 20 + RD_WAIT) ? rx[7 - (c - 12 - RD_WAIT)] : 1'b0;
            if (done_cyc != 0 && c > done_cyc) break;
        end
        miso = 1'b0;
        for (int k = 0; k < 10; k++) sl_frame[9 - k] = tr_mosi[2 + k];
    endtask

    task automatic test_reset;
        rst = 1'b1; #2;
        tests_run++;
        if ({ss_n, mosi, busy, done, rd_valid} !== 5'b10000) begin
            tests_failed++; $display("FAIL reset_outputs: got %b expected 10000", {ss_n, mosi, busy, done, rd_valid});
        end
        tests_run++;
        if (rd_data !== 8'h00) begin
            tests_failed++; $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_frame;
        run_frame(10'b00_1010_0101, 8'h00, -1);
        tests_run++;
        if (done_cyc !== 12) begin tests_failed++; $display("FAIL wr_done_cycle: got %0d expected 12", done_cyc); end
        tests_run++;
        if (sl_frame !== 10'b00_1010_0101) begin tests_failed++; $display("FAIL wr_mosi_bits: got %b expected 0010100101", sl_frame); end
        tests_run++;
        if ({48 - $countones(tr_ss), tr_ss[1], tr_ss[11], tr_ss[12]} !== {11, 3'b001}) begin
            tests_failed++; $display("FAIL wr_ss_window: low=%0d ss1=%b ss11=%b ss12=%b expected 11 0 0 1", 48 - $countones(tr_ss), tr_ss[1], tr_ss[11], tr_ss[12]);
        end
        tests_run++;
        if ({tr_mosi[1], tr_mosi[12], tr_valid[12]} !== 3'b000) begin
            tests_failed++; $display("FAIL wr_idle_mosi_valid: got %b expected 000", {tr_mosi[1], tr_mosi[12], tr_valid[12]});
        end
        tests_run++;
        if ({tr_busy[1], tr_busy[12], tr_busy[13]} !== 3'b110) begin
            tests_failed++; $display("FAIL wr_busy: got %b expected 110", {tr_busy[1], tr_busy[12], tr_busy[13]});
        end
    endtask

    task automatic test_read_frame;
        run_frame(10'b11_0000_0000, 8'hC3, -1);
        tests_run++;
        if (done_cyc !== 23) begin tests_failed++; $display("FAIL rd_done_cycle: got %0d expected 23", done_cyc); end
        tests_run++;
        if ({tr_valid[23], $countones(tr_valid)} !== {1'b1, 1}) begin
            tests_failed++; $display("FAIL rd_valid_pulse: at23=%b count=%0d expected 1 1", tr_valid[23], $countones(tr_valid));
        end
        tests_run++;
        if (rd_at_done !== 8'hC3) begin tests_failed++; $display("FAIL rd_data_capture: got %h expected c3", rd_at_done); end
        tests_run++;
        if ({48 - $countones(tr_ss), tr_ss[22], tr_ss[23]} !== {22, 2'b01}) begin
            tests_failed++; $display("FAIL rd_ss_window: low=%0d ss22=%b ss23=%b expected 22 0 1", 48 - $countones(tr_ss), tr_ss[22], tr_ss[23]);
        end
    endtask

    task automatic test_rd_hold;
        run_frame(10'b10_0101_0101, 8'hFF, -1);
        tests_run++;
        if ({rd_data, 8'($countones(tr_valid))} !== {8'hC3, 8'd0}) begin
            tests_failed++; $display("FAIL rd_hold: rd_data=%h valid_pulses=%0d expected c3 0", rd_data, $countones(tr_valid));
        end
        tests_run++;
        if (done_cyc !== 12) begin tests_failed++; $display("FAIL rd_addr_done_cycle: got %0d expected 12", done_cyc); end
    endtask

    task automatic test_busy_ignore;
        int extra = 0;
        run_frame(10'b01_0110_1001, 8'h00, 5);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        tests_run++;
        if ({done_cyc, $countones(tr_done) + extra} !== {12, 1}) begin
            tests_failed++; $display("FAIL busy_ignore_done: cycle=%0d pulses=%0d expected 12 1", done_cyc, $countones(tr_done) + extra);
        end
        tests_run++;
        if ({sl_frame, busy} !== {10'b01_0110_1001, 1'b0}) begin
            tests_failed++; $display("FAIL busy_ignore_frame: got %b busy=%b expected 0101101001 0", sl_frame, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] ss = '1;
        logic [47:0] dn = '0;
        logic [9:0]  f2 = '0;
        start = 1'b1; cmd_data = 10'b01_1100_0011;
        for (int c = 1; c < 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) cmd_data = 10'b00_0101_1010;
            if (c == 39) start = 1'b0;
            ss[c] = ss_n; dn[c] = done;
            if (c >= 15 && c <= 24) f2[24 - c] = mosi;
        end
        @(posedge clk); #1;
        tests_run++;
        if ($countones(dn) !== 3 || {dn[12], dn[25], dn[38]} !== 3'b111) begin
            tests_failed++; $display("FAIL b2b_done: pulses=%0d at=%b expected 3 111", $countones(dn), {dn[12], dn[25], dn[38]});
        end
        tests_run++;
        if ({ss[11], ss[12], ss[13], ss[14], ss[25], ss[26], ss[27]} !== 7'b0110110) begin
            tests_failed++; $display("FAIL b2b_ss_gap: got %b expected 0110110", {ss[11], ss[12], ss[13], ss[14], ss[25], ss[26], ss[27]});
        end
        tests_run++;
        if (f2 !== 10'b00_0101_1010) begin tests_failed++; $display("FAIL b2b_resample: got %b expected 0001011010", f2); end
    endtask

    task automatic test_loopback;
        logic [7:0] ram [256];
        logic [7:0] addr = 8'h00;
        logic [9:0] cmds [4] = '{10'b00_0001_0010, 10'b01_0101_1010, 10'b10_0001_0010, 10'b11_0000_0000};
        foreach (ram[i]) ram[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            run_frame(cmds[i], ram[addr], -1);
            case (sl_frame[9:8])
                2'b00:   addr = sl_frame[7:0];
                2'b01:   ram[addr] = sl_frame[7:0];
                2'b10:   addr = sl_frame[7:0];
                default: ;
            endcase
        end
        tests_run++;
        if ({rd_at_done, rd_data} !== {8'h5A, 8'h5A}) begin
            tests_failed++; $display("FAIL loopback: at_done=%h held=%h expected 5a 5a", rd_at_done, rd_data);
        end
    endtask

    task automatic test_reset_mid;
        int dn = 0;
        start = 1'b1; cmd_data = 10'b01_1111_1111;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        tests_run++;
        if ({ss_n, mosi} !== 2'b01) begin tests_failed++; $display("FAIL mid_pre_reset: ss_n,mosi=%b expected 01", {ss_n, mosi}); end
        rst = 1'b1; #1;
        tests_run++;
        if ({ss_n, mosi, busy, done, rd_valid, rd_data} !== {5'b10000, 8'h00}) begin
            tests_failed++; $display("FAIL mid_reset_force: got %b %h expected 10000 00", {ss_n, mosi, busy, done, rd_valid}, rd_data);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done || rd_valid) dn++;
        end
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done || rd_valid) dn++;
        end
        tests_run++;
        if (dn !== 0) begin tests_failed++; $display("FAIL mid_no_done: got %0d pulses expected 0", dn); end
        run_frame(10'b01_0011_1100, 8'h00, -1);
        tests_run++;
        if ({done_cyc, 22'(sl_frame)} !== {12, 22'(10'b01_0011_1100)}) begin
            tests_failed++; $display("FAIL mid_next_frame: cycle=%0d frame=%b expected 12 0100111100", done_cyc, sl_frame);
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_write_frame;
        test_read_frame;
        test_rd_hold;
        test_busy_ignore;
        test_back_to_back;
        test_loopback;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
